// File: rtl/hog_window_scheduler.sv
// Slides a WIN_BXxWIN_BY block window over the frame, streaming block requests (1/cycle, held while iBlkReady low), then flags SVM scores above THRESH.
// Score-to-next-window latency 2 cycles; optional iAbort scan cancel under `define HOG_SCAN_ABORT_EN.
module hog_window_scheduler #(
  parameter int                 CELLS_X = 20,
  parameter int                 CELLS_Y = 30,
  parameter int                 WIN_BX  = 7,
  parameter int                 WIN_BY  = 15,
  parameter logic signed [15:0] THRESH  = 16'sd0
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
`ifdef HOG_SCAN_ABORT_EN
  input  logic        iAbort,
`endif
  output logic        oBusy,
  output logic        oBlkValid,
  input  logic        iBlkReady,
  output logic [6:0]  oBlkIdx,
  output logic [7:0]  oBlkX,
  output logic [7:0]  oBlkY,
  output logic        oWinLast,
  input  logic        iScoreValid,
  input  logic [15:0] iScore,
  output logic        oDetValid,
  output logic [7:0]  oDetX,
  output logic [7:0]  oDetY,
  output logic [15:0] oDetScore,
  output logic        oDone
);

  localparam logic [7:0] WX_LAST  = 8'(CELLS_X - WIN_BX - 1);
  localparam logic [7:0] WY_LAST  = 8'(CELLS_Y - WIN_BY - 1);
  localparam logic [7:0] BX_LAST  = 8'(WIN_BX - 1);
  localparam logic [6:0] IDX_LAST = 7'(WIN_BX * WIN_BY - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ADV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  winx_q, winy_q, bx_q, by_q;
  logic [6:0]  idx_q;
  logic        det_vld_q, done_q;
  logic [7:0]  det_x_q, det_y_q;
  logic [15:0] det_score_q;
  logic        abort, abort_now, xfer, win_last, frame_last, hit;

`ifdef HOG_SCAN_ABORT_EN
  assign abort = iAbort;
`else
  assign abort = 1'b0;
`endif

  // DONE already returns to IDLE and pulses oDone, so abort there must not add a second pulse.
  assign abort_now  = abort && (state_q != S_IDLE) && (state_q != S_DONE);
  assign xfer       = (state_q == S_ISSUE) && iBlkReady;
  assign win_last   = (idx_q == IDX_LAST);
  assign frame_last = (winx_q == WX_LAST) && (winy_q == WY_LAST);
  assign hit        = $signed(iScore) > THRESH;

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_ISSUE;
      S_ISSUE: if (xfer && win_last) state_d = S_WAIT;
      S_WAIT:  if (iScoreValid) state_d = S_ADV;
      S_ADV:   state_d = frame_last ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_now) state_d = S_IDLE;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      winx_q      <= '0;
      winy_q      <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      idx_q       <= '0;
      det_vld_q   <= 1'b0;
      det_x_q     <= '0;
      det_y_q     <= '0;
      det_score_q <= '0;
      done_q      <= 1'b0;
    end else begin
      det_vld_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort_now) begin
        done_q <= 1'b1;
        winx_q <= '0;
        winy_q <= '0;
        bx_q   <= '0;
        by_q   <= '0;
        idx_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (iStart) begin
            winx_q <= '0;
            winy_q <= '0;
            bx_q   <= '0;
            by_q   <= '0;
            idx_q  <= '0;
          end
          S_ISSUE: if (xfer) begin
            idx_q <= win_last ? 7'd0 : idx_q + 7'd1;
            if (bx_q == BX_LAST) begin
              bx_q <= '0;
              by_q <= win_last ? 8'd0 : by_q + 8'd1;
            end else begin
              bx_q <= bx_q + 8'd1;
            end
          end
          S_WAIT: if (iScoreValid && hit) begin
            det_vld_q   <= 1'b1;
            det_x_q     <= winx_q;
            det_y_q     <= winy_q;
            det_score_q <= iScore;
          end
          S_ADV: begin
            if (frame_last) begin
              winx_q <= '0;
              winy_q <= '0;
              done_q <= 1'b1;
            end else if (winx_q == WX_LAST) begin
              winx_q <= '0;
              winy_q <= winy_q + 8'd1;
            end else begin
              winx_q <= winx_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign oBusy     = (state_q != S_IDLE);
  assign oBlkValid = (state_q == S_ISSUE);
  assign oBlkIdx   = idx_q;
  assign oBlkX     = winx_q + bx_q;
  assign oBlkY     = winy_q + by_q;
  assign oWinLast  = (state_q == S_ISSUE) && win_last;
  assign oDetValid = det_vld_q;
  assign oDetX     = det_x_q;
  assign oDetY     = det_y_q;
  assign oDetScore = det_score_q;
  assign oDone     = done_q;

endmodule

// File: tb/tb_hog_window_scheduler.sv
// Directed bench for hog_window_scheduler on a 9x17-cell frame (2x2 = 4 windows).
module tb_hog_window_scheduler;

  logic        iClk, iRst, iStart, iBlkReady, iScoreValid;
  logic [15:0] iScore;
  logic        oBusy, oBlkValid, oWinLast, oDetValid, oDone;
  logic [6:0]  oBlkIdx;
  logic [7:0]  oBlkX, oBlkY, oDetX, oDetY;
  logic [15:0] oDetScore;
`ifdef HOG_SCAN_ABORT_EN
  logic        iAbort;
`endif

  int total = 0;
  int bad   = 0;

  hog_window_scheduler #(.CELLS_X(9), .CELLS_Y(17)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
`ifdef HOG_SCAN_ABORT_EN
    .iAbort(iAbort),
`endif
    .oBusy(oBusy), .oBlkValid(oBlkValid), .iBlkReady(iBlkReady),
    .oBlkIdx(oBlkIdx), .oBlkX(oBlkX), .oBlkY(oBlkY), .oWinLast(oWinLast),
    .iScoreValid(iScoreValid), .iScore(iScore),
    .oDetValid(oDetValid), .oDetX(oDetX), .oDetY(oDetY), .oDetScore(oDetScore),
    .oDone(oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start, rdy, sv;
    logic [15:0] score;
    logic        e_vld;
    int          e_idx, e_x, e_y;
    logic        e_last, e_busy;
  } vec_t;

  vec_t vt [12];

  // Scores one full frame; window w sits at (w%2, w/2).
  task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                           input bit rand_rdy, input bit noise);
    int sc [4];
    int e, guard, wx, wy;
    sc = '{s0, s1, s2, s3};
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int w = 0; w < 4; w++) begin
      wx = w % 2;
      wy = w / 2;
      e = 0;
      guard = 0;
      while (e < 105 && guard < 1000) begin
        chk("blk_vld", oBlkValid, 1);
        chk("blk_idx", oBlkIdx, e);
        chk("blk_x", oBlkX, wx + e % 7);
        chk("blk_y", oBlkY, wy + e / 7);
        chk("win_last", oWinLast, (e == 104) ? 1 : 0);
        chk("det_quiet", oDetValid, 0);
        chk("done_quiet", oDone, 0);
        chk("busy", oBusy, 1);
        iBlkReady   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        iScoreValid = noise;
        iScore      = 16'd1000;
        iStart      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (iBlkReady) e++;
        guard++;
        @(negedge iClk);
      end
      chk("win_xfers", e, 105);
      iBlkReady   = 1'b0;
      iScoreValid = 1'b0;
      iStart      = noise;
      chk("wait_vld", oBlkValid, 0);
      chk("wait_busy", oBusy, 1);
      chk("wait_det", oDetValid, 0);
      @(negedge iClk);
      iStart = 1'b0;
      chk("wait_vld2", oBlkValid, 0);
      iScoreValid = 1'b1;
      iScore      = 16'(sc[w]);
      @(negedge iClk);
      iScoreValid = 1'b0;
      chk("det_vld", oDetValid, (sc[w] > 0) ? 1 : 0);
      if (sc[w] > 0) begin
        chk("det_x", oDetX, wx);
        chk("det_y", oDetY, wy);
        chk("det_score", int'($signed(oDetScore)), sc[w]);
      end
      chk("adv_vld", oBlkValid, 0);
      @(negedge iClk);
      if (w == 3) begin
        chk("done_pulse", oDone, 1);
        chk("done_busy", oBusy, 1);
        chk("done_vld", oBlkValid, 0);
        @(negedge iClk);
        chk("done_clear", oDone, 0);
        chk("idle_busy", oBusy, 0);
        chk("idle_vld", oBlkValid, 0);
      end
    end
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iBlkReady = 1'b0; iScoreValid = 1'b0; iScore = '0;
`ifdef HOG_SCAN_ABORT_EN
    iAbort = 1'b0;
`endif
    vt[0]  = '{1'b1, 1'b0, 1'b0, 16'd0,    1'b0, 0, 0, 0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 0, 0, 0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 0, 0, 0, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 1, 1, 0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 2, 2, 0, 1'b0, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 3, 3, 0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 4, 4, 0, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 5, 5, 0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 16'd0,    1'b1, 6, 6, 0, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 16'd1000, 1'b1, 7, 0, 1, 1'b0, 1'b1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 8, 1, 1, 1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b0, 16'd0,    1'b1, 8, 1, 1, 1'b0, 1'b1};

    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    chk("rst_det", oDetValid, 0);
    chk("rst_done", oDone, 0);
    chk("rst_detx", oDetX, 0);
    chk("rst_dets", oDetScore, 0);

    for (int i = 0; i < 12; i++) begin
      chk("tbl_vld", oBlkValid, vt[i].e_vld);
      chk("tbl_idx", oBlkIdx, vt[i].e_idx);
      chk("tbl_x", oBlkX, vt[i].e_x);
      chk("tbl_y", oBlkY, vt[i].e_y);
      chk("tbl_last", oWinLast, vt[i].e_last);
      chk("tbl_busy", oBusy, vt[i].e_busy);
      chk("tbl_det", oDetValid, 0);
      chk("tbl_done", oDone, 0);
      iStart      = vt[i].start;
      iBlkReady   = vt[i].rdy;
      iScoreValid = vt[i].sv;
      iScore      = vt[i].score;
      @(negedge iClk);
    end

    // 8 transfers so far; push to 50 then reset mid-scan.
    iBlkReady = 1'b1;
    repeat (42) @(negedge iClk);
    chk("pre_rst_idx", oBlkIdx, 50);
    iRst = 1'b1;
    iBlkReady = 1'b0;
    @(negedge iClk);
    iRst = 1'b0;
    chk("mrst_vld", oBlkValid, 0);
    chk("mrst_busy", oBusy, 0);
    chk("mrst_done", oDone, 0);
    chk("mrst_det", oDetValid, 0);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    chk("restart_vld", oBlkValid, 1);
    chk("restart_idx", oBlkIdx, 0);
    chk("restart_x", oBlkX, 0);
    chk("restart_y", oBlkY, 0);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;

    run_frame(-5, -5, -5, -5, 1'b0, 1'b0);
    run_frame(-1, 0, 1, 300, 1'b0, 1'b1);
    chk("hold_detx", oDetX, 1);
    chk("hold_dety", oDetY, 1);
    chk("hold_dets", int'($signed(oDetScore)), 300);
    run_frame(2, -3, -3, -3, 1'b1, 1'b0);

`ifdef HOG_SCAN_ABORT_EN
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    iBlkReady = 1'b1;
    repeat (105) @(negedge iClk);
    iBlkReady = 1'b0;
    chk("abt_wait_vld", oBlkValid, 0);
    iScoreValid = 1'b1;
    iScore = 16'd500;
    iAbort = 1'b1;
    @(negedge iClk);
    iScoreValid = 1'b0;
    iAbort = 1'b0;
    chk("abt_det", oDetValid, 0);
    chk("abt_done", oDone, 1);
    chk("abt_busy", oBusy, 0);
    chk("abt_vld", oBlkValid, 0);
    @(negedge iClk);
    chk("abt_done_clr", oDone, 0);
    chk("abt_det2", oDetValid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
